// File: rtl/pes_fmul_arb.sv
// pes_fmul_arb: round-robin issue arbiter sharing one pipelined signed multiplier among N requesters.
// Optional issue counter output enabled by defining PES_FMUL_ARB_STATS_EN.
module pes_fmul_arb #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int LAT = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_x,
    input  logic [N*W-1:0]   req_y,
    output logic [N-1:0]     req_ready,
    output logic [W-1:0]     mul_x,
    output logic [W-1:0]     mul_y,
    output logic             mul_valid,
    input  logic [2*W-1:0]   mul_product,
    output logic             rsp_valid,
    output logic [IW-1:0]    rsp_id,
    output logic [2*W-1:0]   rsp_product,
`ifdef PES_FMUL_ARB_STATS_EN
    output logic [15:0]      issue_cnt,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state, state_nx;
    logic [IW-1:0] ptr, win, mul_id;
    logic [IW-1:0] tid [LAT+1];
    logic [LAT:0]  tv;
    logic          hs, pend;
    // Descending scan so the requester closest to the pointer is the final assignment.
    always_comb begin
        win = ptr;
        for (int k = N - 1; k >= 0; k--)
            if (req_valid[(int'(ptr) + k) % N]) win = IW'((int'(ptr) + k) % N);
        req_ready = '0;
        if (state == ISSUE && |req_valid) req_ready[win] = 1'b1;
        hs = |(req_valid & req_ready);
        pend = mul_valid | |tv;
        busy = (state != IDLE) | pend;
        state_nx = state;
        if (state == IDLE && en) state_nx = ISSUE;
        if (state == ISSUE && !en) state_nx = (hs || pend) ? DRAIN : IDLE;
        if (state == DRAIN && !pend) state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            mul_x       <= '0;
            mul_y       <= '0;
            mul_valid   <= 1'b0;
            mul_id      <= '0;
            tv          <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else begin
            state     <= state_nx;
            mul_valid <= hs;
            if (hs) begin
                mul_x  <= req_x[int'(win)*W +: W];
                mul_y  <= req_y[int'(win)*W +: W];
                mul_id <= win;
                ptr    <= (int'(win) == N - 1) ? '0 : win + 1'b1;
            end
            tv        <= {tv[LAT-1:0], mul_valid};
            rsp_valid <= tv[LAT];
            if (tv[LAT]) begin
                rsp_id      <= tid[LAT];
                rsp_product <= mul_product;
            end
        end
    end
    // Tag ids are qualified by tv, so they need no reset.
    always_ff @(posedge clk) begin
        tid[0] <= mul_id;
        for (int k = 1; k <= LAT; k++) tid[k] <= tid[k-1];
    end
`ifdef PES_FMUL_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) issue_cnt <= '0;
        else if (hs && issue_cnt != 16'hFFFF) issue_cnt <= issue_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pes_fmul_arb.sv
// tb_pes_fmul_arb: directed table-driven bench for pes_fmul_arb with a behavioural multiplier.
// Covers PES_FMUL_ARB_STATS_EN counter saturation when that macro is defined.
module tb_pes_fmul_arb;
    logic        clk, reset, en;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_x, req_y;
    logic [7:0]  mul_x, mul_y;
    logic        mul_valid, rsp_valid, busy;
    logic [15:0] mul_product, rsp_product;
    logic [1:0]  rsp_id;
`ifdef PES_FMUL_ARB_STATS_EN
    logic [15:0] issue_cnt;
`endif
    int pass_cnt = 0, total_cnt = 0, exp_ptr = 0;

    pes_fmul_arb dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
        .mul_x(mul_x), .mul_y(mul_y), .mul_valid(mul_valid), .mul_product(mul_product),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_product(rsp_product),
`ifdef PES_FMUL_ARB_STATS_EN
        .issue_cnt(issue_cnt),
`endif
        .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Multiplier model: product appears LAT+1 edges after the operands are registered.
    logic [15:0] mp [3];
    always @(posedge clk) begin
        mp[0] <= $signed(mul_x) * $signed(mul_y);
        mp[1] <= mp[0];
        mp[2] <= mp[1];
    end
    assign mul_product = mp[2];

    typedef struct {
        int          id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;
    vec_t tbl [6];
    logic [7:0]  rx [4];
    logic [7:0]  ry [4];
    logic [15:0] rp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic do_op(input vec_t v);
        int c = 0;
        @(negedge clk);
        req_valid[v.id] = 1'b1;
        req_x[v.id*8 +: 8] = v.x;
        req_y[v.id*8 +: 8] = v.y;
        #1;
        while (!req_ready[v.id] && c < 10) begin
            @(negedge clk); #1; c++;
        end
        chk("op_grant", 32'(req_ready), 32'(1 << v.id));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("op_rsp_early", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("op_rsp_valid", 32'(rsp_valid), 1);
        chk("op_rsp_id", 32'(rsp_id), 32'(v.id));
        chk("op_rsp_product", 32'(rsp_product), 32'(v.p));
        exp_ptr = (v.id + 1) % 4;
    endtask

    initial begin
        int q[$];
        int g_exp, ngr, nrsp, lr, fb, e, cnt;
        logic [3:0] gp;
        tbl[0] = '{0, 8'h55, 8'h33, 16'h10EF};
        tbl[1] = '{1, 8'hFF, 8'h01, 16'hFFFF};
        tbl[2] = '{2, 8'hAA, 8'h55, 16'hE372};
        tbl[3] = '{3, 8'h0F, 8'h0F, 16'h00E1};
        tbl[4] = '{0, 8'h80, 8'h80, 16'h4000};
        tbl[5] = '{3, 8'h80, 8'h7F, 16'hC080};
        rx = '{8'h55, 8'hFF, 8'hAA, 8'h0F};
        ry = '{8'h33, 8'h01, 8'h55, 8'h0F};
        rp = '{16'h10EF, 16'hFFFF, 16'hE372, 16'h00E1};
        reset = 0; en = 0; req_valid = 4'hF; req_x = '0; req_y = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_mul_valid", 32'(mul_valid), 0);
        chk("rst_mul_x", 32'(mul_x), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_product", 32'(rsp_product), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        req_valid = '0; reset = 1; en = 1;
        for (int i = 0; i < 6; i++) do_op(tbl[i]);

        // Round robin with all requesters continuously valid.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_x[i*8 +: 8] = rx[i];
            req_y[i*8 +: 8] = ry[i];
        end
        req_valid = 4'hF;
        g_exp = exp_ptr; ngr = 0; nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 12) req_valid = '0;
            #1;
            if (req_ready != 0) begin
                chk("rr_grant", 32'(req_ready), 32'(1 << g_exp));
                q.push_back(g_exp);
                g_exp = (g_exp + 1) % 4;
                ngr++;
            end
            if (rsp_valid && q.size() > 0) begin
                e = q.pop_front();
                nrsp++;
                chk("rr_rsp_id", 32'(rsp_id), 32'(e));
                chk("rr_rsp_product", 32'(rsp_product), 32'(rp[e]));
            end
        end
        chk("rr_grants", ngr, 12);
        chk("rr_rsps", nrsp, 12);
        exp_ptr = g_exp;

        // Drain: three back-to-back issues, en dropped during the third grant.
        @(negedge clk);
        req_valid = 4'hF;
        gp = '0; g_exp = exp_ptr; ngr = 0; nrsp = 0; lr = -1; fb = -1;
        q.delete();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            req_valid = req_valid & ~gp;
            if (c == 2) en = 0;
            #1;
            gp = req_ready;
            if (req_ready != 0) begin
                chk("drain_grant", 32'(req_ready), 32'(1 << g_exp));
                q.push_back(g_exp);
                g_exp = (g_exp + 1) % 4;
                ngr++;
            end
            if (rsp_valid && q.size() > 0) begin
                e = q.pop_front();
                nrsp++;
                lr = c;
                chk("drain_rsp_product", 32'(rsp_product), 32'(rp[e]));
            end
            if (!busy && fb < 0) fb = c;
        end
        req_valid = '0;
        chk("drain_grants", ngr, 3);
        chk("drain_rsps", nrsp, 3);
        chk("drain_last_rsp", lr, 7);
        chk("drain_busy_fall", fb, 8);
        exp_ptr = g_exp;

        // Reset with two operations in flight.
        @(negedge clk);
        en = 1; req_valid = 4'b0011; gp = '0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            req_valid = req_valid & ~gp;
            #1;
            gp = req_ready;
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("mid_busy", 32'(busy), 1);
        chk("mid_mul_valid", 32'(mul_valid), 1);
        reset = 0;
        #1;
        chk("mid_rst_mul_valid", 32'(mul_valid), 0);
        chk("mid_rst_mul_x", 32'(mul_x), 0);
        chk("mid_rst_mul_y", 32'(mul_y), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_rsp_id", 32'(rsp_id), 0);
        chk("mid_rst_rsp_product", 32'(rsp_product), 0);
        chk("mid_rst_busy", 32'(busy), 0);
`ifdef PES_FMUL_ARB_STATS_EN
        chk("mid_rst_issue_cnt", 32'(issue_cnt), 0);
`endif
        @(negedge clk);
        reset = 1; en = 0; cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) cnt++;
        end
        chk("no_rsp_after_reset", cnt, 0);
        chk("idle_busy", 32'(busy), 0);

`ifdef PES_FMUL_ARB_STATS_EN
        @(negedge clk);
        en = 1; req_valid = 4'hF;
        @(negedge clk);
        repeat (100) @(negedge clk);
        #1;
        chk("stats_100", 32'(issue_cnt), 100);
        repeat (69910) @(negedge clk);
        #1;
        chk("stats_sat", 32'(issue_cnt), 32'hFFFF);
        req_valid = '0; en = 0;
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
